// File: rtl/time_set_ctrl.sv
`timescale 1ns/1ps
// time_set_ctrl: debounces the mode/inc buttons and runs the time-set sequence,
// ending with a one-cycle load of set_hours/set_minutes into the clock block.
// Ports: clk, rst (sync, active-high), btn_mode, btn_inc (raw buttons),
//   cur_hours/cur_minutes (live time), set_hours/set_minutes (edit value),
//   load (one-cycle strobe), setting (editing), field_sel (0 none, 1 hh, 2 mm).
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic [4:0] set_hours,
    output logic [5:0] set_minutes,
    output logic       load,
    output logic       setting,
    output logic [1:0] field_sel
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = (REPEAT_CYCLES > 0) ?
                        $clog2(REPEAT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } state_t;

    // Index 0 = mode button, index 1 = inc button.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_q;
    logic [1:0]    armed;
    logic [1:0]    press;
    logic [1:0]    rst_dly;
    logic [DW-1:0] cnt [2];

    state_t        state;
    logic [RW-1:0] rcnt;
    logic          rpt;
    logic          mode_evt;
    logic          inc_evt;

    assign raw = {btn_inc, btn_mode};

    // A button held through reset must not count as a press when it is
    // finally accepted; it has to be seen released first. rst_dly waits
    // until the synchronizers carry real samples before trusting them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            deb_q   <= '0;
            armed   <= '0;
            press   <= '0;
            rst_dly <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            deb_q   <= deb;
            rst_dly <= {rst_dly[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 2)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
                if (rst_dly[1] && !sync2[i] && !deb[i])
                    armed[i] <= 1'b1;
                press[i] <= deb[i] & ~deb_q[i] & armed[i];
            end
        end
    end

    assign mode_evt = press[0];
    assign inc_evt  = (press[1] | rpt) & ~press[0];

    // Repeat counter starts on the first cycle inc is debounced-high, so
    // reaching REPEAT_CYCLES lines up exactly REPEAT_CYCLES after the press.
    always_ff @(posedge clk) begin
        if (rst || REPEAT_CYCLES == 0 || !deb[1] || !armed[1] ||
            state == RUN || mode_evt) begin
            rcnt <= '0;
            rpt  <= 1'b0;
        end else if (rcnt == RW'(REPEAT_CYCLES)) begin
            rcnt <= RW'(1);
            rpt  <= 1'b1;
        end else begin
            rcnt <= rcnt + RW'(1);
            rpt  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            set_hours   <= '0;
            set_minutes <= '0;
            load        <= 1'b0;
            setting     <= 1'b0;
            field_sel   <= 2'd0;
        end else begin
            load <= 1'b0;
            case (state)
                RUN: begin
                    if (mode_evt) begin
                        state     <= SET_H;
                        setting   <= 1'b1;
                        field_sel <= 2'd1;
                        set_hours <= (cur_hours > 5'd23) ?
                                     5'd0 : cur_hours;
                        set_minutes <= (cur_minutes > 6'd59) ?
                                       6'd0 : cur_minutes;
                    end
                end
                SET_H: begin
                    if (mode_evt) begin
                        state     <= SET_M;
                        field_sel <= 2'd2;
                    end else if (inc_evt) begin
                        set_hours <= (set_hours >= 5'd23) ?
                                     5'd0 : set_hours + 5'd1;
                    end
                end
                SET_M: begin
                    if (mode_evt) begin
                        state     <= RUN;
                        setting   <= 1'b0;
                        field_sel <= 2'd0;
                        load      <= 1'b1;
                    end else if (inc_evt) begin
                        set_minutes <= (set_minutes >= 6'd59) ?
                                       6'd0 : set_minutes + 6'd1;
                    end
                end
                default: begin
                    state     <= RUN;
                    setting   <= 1'b0;
                    field_sel <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
`timescale 1ns/1ps
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl (DEBOUNCE 4, REPEAT 8).
// Expected output snapshots are queued with each stimulus and popped on change.
module tb_time_set_ctrl;

    localparam int D = 4;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hours = '0;
    logic [5:0] cur_minutes = '0;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic       load;
    logic       setting;
    logic [1:0] field_sel;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hours  (cur_hours),
        .cur_minutes(cur_minutes),
        .set_hours  (set_hours),
        .set_minutes(set_minutes),
        .load       (load),
        .setting    (setting),
        .field_sel  (field_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic       s;
        logic [1:0] f;
        logic       l;
    } snap_t;

    snap_t exp_q[$];
    int    ev_cyc[$];
    snap_t last;
    snap_t now_s;
    snap_t mon_e;
    bit    mon_en = 1'b0;
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;

    always @(posedge clk) cyc++;

    // Scoreboard: every change of the output bundle must match the next
    // expected snapshot.
    always @(negedge clk) begin
        now_s = {set_hours, set_minutes, setting, field_sel, load};
        if (mon_en && now_s !== last) begin
            ev_cyc.push_back(cyc);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard: unexpected change h=%0d m=%0d set=%0b fld=%0d load=%0b",
                         now_s.h, now_s.m, now_s.s, now_s.f, now_s.l);
            end else begin
                mon_e = exp_q.pop_front();
                if (now_s !== mon_e) begin
                    fails++;
                    $display("FAIL scoreboard: got h=%0d m=%0d set=%0b fld=%0d load=%0b, required h=%0d m=%0d set=%0b fld=%0d load=%0b",
                             now_s.h, now_s.m, now_s.s, now_s.f, now_s.l,
                             mon_e.h, mon_e.m, mon_e.s, mon_e.f, mon_e.l);
                end
            end
        end
        last = now_s;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input int h, input int m, input bit s,
                        input int f, input bit l);
        snap_t e;
        e.h = 5'(h);
        e.m = 6'(m);
        e.s = s;
        e.f = 2'(f);
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() > 0; k++) step(1);
        step(4);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(4);
        exp_q.delete();
        ev_cyc.delete();
        mon_en = 1'b1;
    endtask

    // Clean press: 4 cycles high is enough to debounce, 8 low to release.
    task automatic press(input bit m, input bit i);
        btn_mode = m;
        btn_inc = i;
        step(4);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        step(8);
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        cur_hours = 5'd7;
        cur_minutes = 6'd7;
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        rst = 1'b1;
        step(3);
        tests++;
        if ({set_hours, set_minutes, setting, field_sel, load} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %0d:%0d set=%0b fld=%0d load=%0b, required all 0",
                     set_hours, set_minutes, setting, field_sel, load);
        end
        rst = 1'b0;
        step(1);
        ev_cyc.delete();
        mon_en = 1'b1;
        step(20);
        tests++;
        if (ev_cyc.size() != 0 || setting !== 1'b0) begin
            fails++;
            $display("FAIL reset_held_buttons: got %0d events setting=%0b, required 0 events setting=0",
                     ev_cyc.size(), setting);
        end
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        step(8);
        push(7, 7, 1, 1, 0);
        press(1, 0);
        wait_drain(40);
        tests++;
        if (exp_q.size() != 0 || field_sel !== 2'd1) begin
            fails++;
            $display("FAIL reset_repress: got pending=%0d fld=%0d, required pending=0 fld=1",
                     exp_q.size(), field_sel);
        end
    endtask

    task automatic test_bounce();
        int c0;
        do_reset();
        cur_hours = 5'd22;
        cur_minutes = 6'd58;
        btn_mode = 1'b1; step(2);
        btn_mode = 1'b0; step(2);
        btn_mode = 1'b1; step(2);
        btn_mode = 1'b0; step(2);
        btn_mode = 1'b1;
        c0 = cyc;
        push(22, 58, 1, 1, 0);
        step(12);
        btn_mode = 1'b0;
        step(12);
        // press lands D+2 edges after the rise; the FSM moves one edge later
        tests++;
        if (ev_cyc.size() != 1 || ev_cyc[0] - c0 != D + 3) begin
            fails++;
            $display("FAIL bounce_latency: got %0d events, first at +%0d, required 1 at +%0d",
                     ev_cyc.size(), (ev_cyc.size() > 0) ? ev_cyc[0] - c0 : -1, D + 3);
        end
        tests++;
        if (setting !== 1'b1 || field_sel !== 2'd1) begin
            fails++;
            $display("FAIL bounce_state: got set=%0b fld=%0d, required set=1 fld=1",
                     setting, field_sel);
        end
    endtask

    task automatic test_full_edit();
        int n;
        do_reset();
        cur_hours = 5'd22;
        cur_minutes = 6'd58;
        push(22, 58, 1, 1, 0); press(1, 0);
        cur_hours = 5'd3;
        cur_minutes = 6'd3;
        push(23, 58, 1, 1, 0); press(0, 1);
        push(0, 58, 1, 1, 0);  press(0, 1);
        push(0, 58, 1, 2, 0);  press(1, 0);
        push(0, 59, 1, 2, 0);  press(0, 1);
        push(0, 0, 1, 2, 0);   press(0, 1);
        push(0, 1, 1, 2, 0);   press(0, 1);
        push(0, 1, 0, 0, 1);
        push(0, 1, 0, 0, 0);   press(1, 0);
        wait_drain(40);
        n = ev_cyc.size();
        tests++;
        if (exp_q.size() != 0 || n != 9) begin
            fails++;
            $display("FAIL full_edit_events: got %0d events, %0d pending, required 9 and 0",
                     n, exp_q.size());
        end
        tests++;
        if (n < 2 || ev_cyc[n-1] - ev_cyc[n-2] != 1) begin
            fails++;
            $display("FAIL full_edit_load_width: got %0d cycles, required 1",
                     (n < 2) ? -1 : ev_cyc[n-1] - ev_cyc[n-2]);
        end
        cur_hours = 5'd10;
        cur_minutes = 6'd10;
        step(10);
        tests++;
        if (ev_cyc.size() != n || set_hours !== 5'd0 || set_minutes !== 6'd1) begin
            fails++;
            $display("FAIL full_edit_hold: got %0d:%0d events=%0d, required 0:1 events=%0d",
                     set_hours, set_minutes, ev_cyc.size(), n);
        end
    endtask

    task automatic test_auto_repeat();
        int c0;
        bit bad;
        do_reset();
        cur_hours = 5'd9;
        cur_minutes = 6'd10;
        push(9, 10, 1, 1, 0); press(1, 0);
        push(9, 10, 1, 2, 0); press(1, 0);
        wait_drain(40);
        ev_cyc.delete();
        for (int k = 11; k <= 15; k++) push(9, k, 1, 2, 0);
        btn_inc = 1'b1;
        c0 = cyc;
        step(40);
        btn_inc = 1'b0;
        step(30);
        bad = (ev_cyc.size() != 5);
        for (int k = 0; k < ev_cyc.size() && k < 5; k++)
            if (ev_cyc[k] - c0 != D + 3 + R * k) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL auto_repeat_timing: got %0d events (first +%0d), required 5 at +%0d step %0d",
                     ev_cyc.size(), (ev_cyc.size() > 0) ? ev_cyc[0] - c0 : -1, D + 3, R);
        end
        tests++;
        if (set_minutes !== 6'd15 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL auto_repeat_final: got m=%0d pending=%0d, required m=15 pending=0",
                     set_minutes, exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cur_hours = 5'd5;
        cur_minutes = 6'd62;
        push(5, 0, 1, 1, 0); press(1, 0);
        push(5, 0, 1, 2, 0); press(1, 1);
        wait_drain(40);
        step(10);
        tests++;
        if (ev_cyc.size() != 2 || set_hours !== 5'd5 || field_sel !== 2'd2) begin
            fails++;
            $display("FAIL simultaneous: got h=%0d fld=%0d events=%0d, required h=5 fld=2 events=2",
                     set_hours, field_sel, ev_cyc.size());
        end
    endtask

    task automatic test_abort();
        int loads;
        do_reset();
        cur_hours = 5'd12;
        cur_minutes = 6'd30;
        push(12, 30, 1, 1, 0); press(1, 0);
        push(13, 30, 1, 1, 0); press(0, 1);
        push(13, 30, 1, 2, 0); press(1, 0);
        push(13, 31, 1, 2, 0); press(0, 1);
        wait_drain(40);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL abort_edit: got %0d pending, required 0", exp_q.size());
        end
        mon_en = 1'b0;
        loads = 0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            if (load === 1'b1) loads++;
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (load === 1'b1) loads++;
        end
        tests++;
        if (loads != 0 ||
            {set_hours, set_minutes, setting, field_sel} !== 14'd0) begin
            fails++;
            $display("FAIL abort_reset: got loads=%0d %0d:%0d set=%0b fld=%0d, required loads=0 all 0",
                     loads, set_hours, set_minutes, setting, field_sel);
        end
        exp_q.delete();
        ev_cyc.delete();
        mon_en = 1'b1;
        cur_hours = 5'd31;
        cur_minutes = 6'd45;
        push(0, 45, 1, 1, 0); press(1, 0);
        wait_drain(40);
        tests++;
        if (set_hours !== 5'd0 || set_minutes !== 6'd45 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL abort_recapture: got %0d:%0d pending=%0d, required 0:45 pending=0",
                     set_hours, set_minutes, exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bounce();
        test_full_edit();
        test_auto_repeat();
        test_simultaneous();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
